// File: rtl/obstacle_wave_gen.sv
// obstacle_wave_gen: spawns one row of obstacles across LANES lanes, scrolls it
// down on each frame tick, retires it at Y_LIMIT and spawns the next row.
// Every row leaves at least one lane free. Speed rises every WAVES_PER_LEVEL rows.
// Optional build macro: OBST_FIXED_SEQ_EN. It replaces the LFSR with a rotating
// free-lane index (0,1,2,...). When it is undefined the LFSR pattern from SEED is used.
module obstacle_wave_gen #(
  parameter int unsigned LANES           = 3,
  parameter logic [9:0]  LANE_X0         = 10'h0C5,
  parameter logic [9:0]  LANE_PITCH      = 10'h052,
  parameter logic [9:0]  Y_START         = 10'h000,
  parameter logic [9:0]  Y_LIMIT         = 10'h262,
  parameter logic [3:0]  SPEED_INIT      = 4'd2,
  parameter logic [3:0]  SPEED_MAX       = 4'd6,
  parameter int unsigned WAVES_PER_LEVEL = 4,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  frame_tick,
  input  logic                  pause,
  input  logic                  collision,
  output logic [LANES*10-1:0]   obj_x,
  output logic [9:0]            obj_y,
  output logic [LANES-1:0]      obj_en,
  output logic                  wave_done,
  output logic [15:0]           wave_count,
  output logic [3:0]            speed,
  output logic                  running
);

  localparam int unsigned LVL_W = (WAVES_PER_LEVEL > 1) ? $clog2(WAVES_PER_LEVEL) : 1;
  localparam int unsigned K_W   = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPAWN  = 2'd1,
    S_SCROLL = 2'd2,
    S_HIT    = 2'd3
  } state_e;

  // Constant lane x positions, lane i at [10*i +: 10]
  function automatic logic [LANES*10-1:0] lane_x_table();
    logic [LANES*10-1:0] t;
    t = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      t[10*i +: 10] = LANE_X0 + 10'(i) * LANE_PITCH;
    end
    return t;
  endfunction

  localparam logic [LANES*10-1:0] LANE_X_TBL = lane_x_table();

  state_e                state_q, state_d;
  logic [LANES*10-1:0]   obj_x_q;
  logic [9:0]            obj_y_q, obj_y_d;
  logic [LANES-1:0]      obj_en_q, obj_en_d;
  logic                  wave_done_q, wave_done_d;
  logic [15:0]           wave_count_q, wave_count_d;
  logic [3:0]            speed_q, speed_d;
  logic                  running_q, running_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [LANES-1:0]      pat_c;
  logic [10:0]           sum_c;

`ifdef OBST_FIXED_SEQ_EN
  logic [K_W-1:0]        lane_k_q, lane_k_d;

  // Free lane rotates through 0..LANES-1
  always_comb begin
    pat_c = '1;
    pat_c[lane_k_q] = 1'b0;
  end
`else
  logic [15:0]           lfsr_q, lfsr_d;
  logic [15:0]           lfsr_next_c;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB
  always_comb begin
    lfsr_next_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Row mask from the low LFSR bits, forced to keep one obstacle and one free lane
  always_comb begin
    pat_c = lfsr_q[LANES-1:0];
    if (&pat_c) begin
      pat_c[LANES-1] = 1'b0;
    end else if (pat_c == '0) begin
      pat_c[0] = 1'b1;
    end
  end
`endif

  // Candidate y after one tick, one extra bit so the limit compare cannot wrap
  always_comb begin
    sum_c = {1'b0, obj_y_q} + {7'd0, speed_q};
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    obj_y_d      = obj_y_q;
    obj_en_d     = obj_en_q;
    wave_done_d  = 1'b0;
    wave_count_d = wave_count_q;
    speed_d      = speed_q;
    level_d      = level_q;
`ifdef OBST_FIXED_SEQ_EN
    lane_k_d     = lane_k_q;
`else
    lfsr_d       = lfsr_q;
`endif

    unique case (state_q)
      S_IDLE, S_HIT: begin
        if (start) begin
          state_d      = S_SPAWN;
          wave_count_d = 16'd0;
          level_d      = '0;
          speed_d      = SPEED_INIT;
`ifdef OBST_FIXED_SEQ_EN
          lane_k_d     = '0;
`else
          lfsr_d       = SEED;
`endif
        end
      end

      S_SPAWN: begin
        obj_y_d  = Y_START;
        obj_en_d = pat_c;
`ifdef OBST_FIXED_SEQ_EN
        lane_k_d = (lane_k_q == K_W'(LANES - 1)) ? '0 : lane_k_q + K_W'(1);
`else
        lfsr_d   = lfsr_next_c;
`endif
        state_d  = S_SCROLL;
      end

      S_SCROLL: begin
        if (collision) begin
          state_d = S_HIT;
        end else if (pause) begin
          state_d = S_SCROLL;
        end else if (frame_tick) begin
          if (sum_c >= {1'b0, Y_LIMIT}) begin
            obj_en_d     = '0;
            wave_done_d  = 1'b1;
            wave_count_d = wave_count_q + 16'd1;
            state_d      = S_SPAWN;
            if (level_q == LVL_W'(WAVES_PER_LEVEL - 1)) begin
              level_d = '0;
              speed_d = (speed_q < SPEED_MAX) ? speed_q + 4'd1 : SPEED_MAX;
            end else begin
              level_d = level_q + LVL_W'(1);
            end
          end else begin
            obj_y_d = sum_c[9:0];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_SPAWN) || (state_d == S_SCROLL);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      obj_x_q      <= LANE_X_TBL;
      obj_y_q      <= Y_START;
      obj_en_q     <= '0;
      wave_done_q  <= 1'b0;
      wave_count_q <= 16'd0;
      speed_q      <= SPEED_INIT;
      running_q    <= 1'b0;
      level_q      <= '0;
`ifdef OBST_FIXED_SEQ_EN
      lane_k_q     <= '0;
`else
      lfsr_q       <= SEED;
`endif
    end else begin
      state_q      <= state_d;
      obj_x_q      <= LANE_X_TBL;
      obj_y_q      <= obj_y_d;
      obj_en_q     <= obj_en_d;
      wave_done_q  <= wave_done_d;
      wave_count_q <= wave_count_d;
      speed_q      <= speed_d;
      running_q    <= running_d;
      level_q      <= level_d;
`ifdef OBST_FIXED_SEQ_EN
      lane_k_q     <= lane_k_d;
`else
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign obj_x      = obj_x_q;
  assign obj_y      = obj_y_q;
  assign obj_en     = obj_en_q;
  assign wave_done  = wave_done_q;
  assign wave_count = wave_count_q;
  assign speed      = speed_q;
  assign running    = running_q;

endmodule

// File: tb/tb_obstacle_wave_gen.sv
// Bench for obstacle_wave_gen (default parameters, LANES=3).
module tb_obstacle_wave_gen;

  localparam int unsigned LANES = 3;
  localparam int Y_LIM = 610;

  logic                clk = 1'b0;
  logic                reset, start, frame_tick, pause, collision;
  logic [LANES*10-1:0] obj_x;
  logic [9:0]          obj_y;
  logic [LANES-1:0]    obj_en;
  logic                wave_done;
  logic [15:0]         wave_count;
  logic [3:0]          speed;
  logic                running;

  obstacle_wave_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .pause      (pause),
    .collision  (collision),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_en     (obj_en),
    .wave_done  (wave_done),
    .wave_count (wave_count),
    .speed      (speed),
    .running    (running)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Game-level reference: idle / about to place a row / row on screen / crashed
  localparam int G_IDLE = 0, G_PLACE = 1, G_ONSCREEN = 2, G_CRASHED = 3;
  int m_phase, m_y, m_en, m_count, m_wd, m_lfsr, m_k;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Speed is a function of rows cleared since start: +1 per 4 rows, capped at 6
  function automatic int m_speed();
    int s;
    s = 2 + m_count / 4;
    return (s > 6) ? 6 : s;
  endfunction

  function automatic int m_pattern();
    int m;
`ifdef OBST_FIXED_SEQ_EN
    m = 7 & ~(1 << m_k);
`else
    m = m_lfsr % 8;
    if (m == 7) m = 3;
    if (m == 0) m = 1;
`endif
    return m;
  endfunction

  task automatic model_reset();
    m_phase = G_IDLE; m_y = 0; m_en = 0; m_count = 0; m_wd = 0;
    m_lfsr = 16'hACE1; m_k = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input bit pa, input bit co);
    m_wd = 0;
    case (m_phase)
      G_IDLE, G_CRASHED: begin
        if (st) begin
          m_phase = G_PLACE; m_count = 0; m_lfsr = 16'hACE1; m_k = 0;
        end
      end
      G_PLACE: begin
        m_y = 0;
        m_en = m_pattern();
        m_lfsr = ((m_lfsr << 1) | (^(m_lfsr & 16'hB400))) & 16'hFFFF;
        m_k = (m_k + 1) % LANES;
        m_phase = G_ONSCREEN;
      end
      default: begin
        if (co) m_phase = G_CRASHED;
        else if (!pa && tk) begin
          if (m_y + m_speed() >= Y_LIM) begin
            m_en = 0; m_wd = 1; m_count = (m_count + 1) & 16'hFFFF;
            m_phase = G_PLACE;
          end else begin
            m_y = m_y + m_speed();
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check_eq("obj_y", 32'(obj_y), 32'(m_y));
    check_eq("obj_en", 32'(obj_en), 32'(m_en));
    check_eq("wave_done", 32'(wave_done), 32'(m_wd));
    check_eq("wave_count", 32'(wave_count), 32'(m_count));
    check_eq("speed", 32'(speed), 32'(m_speed()));
    check_eq("running", 32'(running), 32'(m_phase == G_PLACE || m_phase == G_ONSCREEN));
    if (m_phase == G_ONSCREEN)
      check_eq("free_lane", 32'(obj_en != 3'b111 && obj_en != 3'b000), 32'd1);
  endtask

  task automatic cycle(input bit st, input bit tk, input bit pa, input bit co);
    @(negedge clk);
    start = st; frame_tick = tk; pause = pa; collision = co;
    model_step(st, tk, pa, co);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset asserted between clock edges, checked before any edge arrives
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("obj_x_rst", 32'(obj_x), {2'b0, 10'h169, 10'h117, 10'h0C5});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit pa_lvl;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; pause = 1'b0; collision = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    compare_all();
    check_eq("obj_x", 32'(obj_x), {2'b0, 10'h169, 10'h117, 10'h0C5});

    // First row at speed 2: tick during the spawn cycle is dropped, 305th tick retires
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check_eq("spawn_y", 32'(obj_y), 32'd0);
    for (int i = 0; i < 304; i++) cycle(0, 1, 0, 0);
    check_eq("last_y", 32'(obj_y), 32'd608);
    cycle(0, 1, 0, 0);
    check_eq("retire_pulse", 32'(wave_done), 32'd1);
    check_eq("retire_count", 32'(wave_count), 32'd1);
    cycle(0, 1, 0, 0);
    check_eq("pulse_one_cycle", 32'(wave_done), 32'd0);
    check_eq("respawn_y", 32'(obj_y), 32'd0);

    // Collision together with a tick at y=100 freezes everything until start
    for (int i = 0; i < 50; i++) cycle(0, 1, 0, 0);
    check_eq("y_before_hit", 32'(obj_y), 32'd100);
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 50; i++) cycle(0, 1, i % 3 == 0, 0);
    check_eq("hit_hold_y", 32'(obj_y), 32'd100);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check_eq("restart_count", 32'(wave_count), 32'd0);
    check_eq("restart_speed", 32'(speed), 32'd2);

    // Pause held over ticks at y=40, then one tick
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 0);
    check_eq("pause_y", 32'(obj_y), 32'd40);
    cycle(0, 1, 0, 0);
    check_eq("unpause_y", 32'(obj_y), 32'd42);

    // Async reset in the middle of a row
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 0);
    async_reset();

    // Randomized play: many rows, occasional pauses, collisions, restarts, resets
    cycle(1, 0, 0, 0);
    pa_lvl = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if ($urandom_range(0, 39) == 0) pa_lvl = ~pa_lvl;
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0,
            pa_lvl,
            $urandom_range(0, 3999) == 0);
      if ($urandom_range(0, 9999) == 0) async_reset();
    end
    check_eq("rows_progressed", 32'(m_count > 0 || m_phase != G_ONSCREEN), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
